// File: rtl/eth_rx_frame_check_if.sv
// Byte stream in from the MII packer, payload bytes and
// per-frame status out toward the receive FIFO.
interface eth_rx_frame_check_if;
  logic        rx_dv;
  logic        rx_er;
  logic        in_vld;
  logic [7:0]  in_byte;
  logic        promisc;
  logic        out_vld;
  logic [7:0]  out_byte;
  logic        sof;
  logic        eof;
  logic        stat_vld;
  logic [3:0]  stat_err;
  logic [10:0] stat_len;
  logic [15:0] pre_err_cnt;

  modport master (
    output rx_dv, rx_er, in_vld, in_byte, promisc,
    input  out_vld, out_byte, sof, eof,
    input  stat_vld, stat_err, stat_len, pre_err_cnt
  );

  modport slave (
    input  rx_dv, rx_er, in_vld, in_byte, promisc,
    output out_vld, out_byte, sof, eof,
    output stat_vld, stat_err, stat_len, pre_err_cnt
  );
endinterface

// File: rtl/eth_rx_frame_check.sv
// Ethernet receive frame checker: preamble strip, CRC-32,
// length/DA checks, FCS removal and per-frame status.
module eth_rx_frame_check #(
  parameter bit          NIBBLE_SWAP = 1'b1,
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
  parameter int          MIN_LEN     = 64,
  parameter int          MAX_LEN     = 1518
) (
  input logic i_rx_clk,
  input logic i_rstn,
  eth_rx_frame_check_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_END  = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;
  localparam logic [11:0] MIN_L    = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L    = 12'(MAX_LEN);

  logic [2:0]       state;
  logic             dv_q;
  logic [31:0]      crc;
  logic [4:0][7:0]  line;
  logic [2:0]       cnt;
  logic [11:0]      tot;
  logic             loc_ok;
  logic             bc_ok;
  logic             er;
  logic             sent;

  logic             out_vld;
  logic [7:0]       out_byte;
  logic             sof;
  logic             eof;
  logic             stat_vld;
  logic [3:0]       stat_err;
  logic [10:0]      stat_len;
  logic [15:0]      pre_cnt;

  logic [7:0]  b;
  logic [7:0]  mac_b;
  logic [11:0] pay;
  logic [10:0] slen;
  logic        rise;
  logic        crc_err;
  logic        len_err;
  logic        addr_miss;

  function automatic logic [31:0] crc8(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320)
               : (r >> 1);
    return r;
  endfunction

  assign b = NIBBLE_SWAP
    ? {bus.in_byte[3:0], bus.in_byte[7:4]}
    : bus.in_byte;

  assign rise = bus.rx_dv && !dv_q;

  always_comb begin
    mac_b = 8'h00;
    case (tot[2:0])
      3'd0:    mac_b = LOCAL_MAC[47:40];
      3'd1:    mac_b = LOCAL_MAC[39:32];
      3'd2:    mac_b = LOCAL_MAC[31:24];
      3'd3:    mac_b = LOCAL_MAC[23:16];
      3'd4:    mac_b = LOCAL_MAC[15:8];
      3'd5:    mac_b = LOCAL_MAC[7:0];
      default: mac_b = 8'h00;
    endcase
  end

  // payload length is everything after SFD minus the FCS
  assign pay = tot - 12'd4;
  always_comb begin
    slen = '0;
    if (tot < 12'd5)
      slen = '0;
    else if (pay > 12'd2047)
      slen = 11'h7FF;
    else
      slen = pay[10:0];
  end

  assign crc_err   = (crc != CRC_RES);
  assign len_err   = (tot < MIN_L) || (tot > MAX_L);
  assign addr_miss = !bus.promisc &&
    ((tot < 12'd6) || !(loc_ok || bc_ok));

  always_ff @(posedge i_rx_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= S_IDLE;
      dv_q     <= 1'b0;
      crc      <= CRC_INIT;
      line     <= '0;
      cnt      <= '0;
      tot      <= '0;
      loc_ok   <= 1'b1;
      bc_ok    <= 1'b1;
      er       <= 1'b0;
      sent     <= 1'b0;
      out_vld  <= 1'b0;
      out_byte <= '0;
      sof      <= 1'b0;
      eof      <= 1'b0;
      stat_vld <= 1'b0;
      stat_err <= '0;
      stat_len <= '0;
      pre_cnt  <= '0;
    end else begin
      dv_q     <= bus.rx_dv;
      out_vld  <= 1'b0;
      sof      <= 1'b0;
      eof      <= 1'b0;
      stat_vld <= 1'b0;
      if (bus.rx_er && bus.rx_dv &&
          (state == S_PRE || state == S_DATA))
        er <= 1'b1;
      unique case (1'b1)
        (state == S_IDLE): begin
          er <= 1'b0;
          if (rise)
            state <= S_PRE;
        end
        (state == S_PRE): begin
          if (!bus.rx_dv)
            state <= S_IDLE;
          else if (bus.in_vld) begin
            if (b == 8'hD5)
              state <= S_DATA;
            else if (b != 8'h55) begin
              state <= S_DROP;
              if (pre_cnt != 16'hFFFF)
                pre_cnt <= pre_cnt + 16'd1;
            end
          end
        end
        (state == S_DATA): begin
          if (bus.in_vld) begin
            crc  <= crc8(crc, b);
            line <= {line[3:0], b};
            if (cnt == 3'd5) begin
              out_vld  <= 1'b1;
              out_byte <= line[4];
              sof      <= !sent;
              sent     <= 1'b1;
            end else
              cnt <= cnt + 3'd1;
            if (tot != 12'hFFF)
              tot <= tot + 12'd1;
            if (tot < 12'd6) begin
              if (b != mac_b)
                loc_ok <= 1'b0;
              if (b != 8'hFF)
                bc_ok <= 1'b0;
            end
          end
          if (!bus.rx_dv)
            state <= S_END;
        end
        (state == S_END): begin
          stat_vld <= 1'b1;
          stat_err <= {er, addr_miss, len_err, crc_err};
          stat_len <= slen;
          // the other four bytes in the line are the FCS
          if (cnt == 3'd5) begin
            out_vld  <= 1'b1;
            out_byte <= line[4];
            sof      <= !sent;
            eof      <= 1'b1;
          end
          crc    <= CRC_INIT;
          line   <= '0;
          cnt    <= '0;
          tot    <= '0;
          loc_ok <= 1'b1;
          bc_ok  <= 1'b1;
          sent   <= 1'b0;
          er     <= 1'b0;
          state  <= rise ? S_PRE : S_IDLE;
        end
        (state == S_DROP): begin
          if (!bus.rx_dv)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_vld     = out_vld;
  assign bus.out_byte    = out_byte;
  assign bus.sof         = sof;
  assign bus.eof         = eof;
  assign bus.stat_vld    = stat_vld;
  assign bus.stat_err    = stat_err;
  assign bus.stat_len    = stat_len;
  assign bus.pre_err_cnt = pre_cnt;
endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Directed bench for eth_rx_frame_check: good, bad-CRC, length,
// preamble, address, runt, rx_er, back-to-back and reset cases.
module tb_eth_rx_frame_check;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  eth_rx_frame_check_if bus();

  eth_rx_frame_check #(
    .NIBBLE_SWAP(1'b1),
    .LOCAL_MAC(48'h02_00_00_00_00_01),
    .MIN_LEN(64),
    .MAX_LEN(1518)
  ) dut (
    .i_rx_clk(clk),
    .i_rstn(rstn),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] frm [0:2047];
  logic [7:0] got [0:2047];
  int n_out, sof_n, sof_idx, eof_n, eof_idx, stat_n;
  logic [3:0]  s_err, err_or;
  logic [10:0] s_len;
  int flip_idx = -1;
  int er_idx   = -1;
  int bad_pre  = -1;

  always @(negedge clk) begin
    if (bus.out_vld) begin
      if (n_out < 2048) got[n_out] = bus.out_byte;
      if (bus.sof) begin sof_n++; sof_idx = n_out; end
      if (bus.eof) begin eof_n++; eof_idx = n_out; end
      n_out++;
    end
    if (bus.stat_vld) begin
      stat_n++;
      s_err  = bus.stat_err;
      s_len  = bus.stat_len;
      err_or = err_or | bus.stat_err;
    end
  end

  task automatic clr();
    n_out = 0; sof_n = 0; sof_idx = -1;
    eof_n = 0; eof_idx = -1; stat_n = 0;
    s_err = 4'h0; s_len = 11'h0; err_or = 4'h0;
  endtask

  task automatic build(input logic [47:0] da, input int n);
    for (int k = 0; k < n; k++) begin
      if (k < 6)       frm[k] = da[47-8*k -: 8];
      else if (k < 12) frm[k] = 8'(8'hA0 + k);
      else             frm[k] = 8'(k * 7 + 3);
    end
  endtask

  function automatic logic [31:0] tb_crc(input int n);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ frm[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return c;
  endfunction

  task automatic put(input logic [7:0] v, input logic e);
    @(negedge clk);
    bus.in_vld  = 1'b1;
    bus.in_byte = {v[3:0], v[7:4]};
    bus.rx_er   = e;
  endtask

  task automatic send_frame(input int n, input bit fcs);
    logic [31:0] f;
    logic [7:0]  v;
    f = ~tb_crc(n);
    @(negedge clk);
    bus.rx_dv  = 1'b1;
    bus.in_vld = 1'b0;
    for (int i = 0; i < 7; i++)
      put((i == bad_pre) ? 8'h57 : 8'h55, 1'b0);
    put(8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      v = frm[i];
      if (i == flip_idx) v = v ^ 8'h10;
      put(v, i == er_idx);
    end
    if (fcs)
      for (int k = 0; k < 4; k++) put(f[8*k +: 8], 1'b0);
    @(negedge clk);
    bus.in_vld = 1'b0;
    bus.rx_er  = 1'b0;
    bus.rx_dv  = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [42:0] o;
    o = {bus.out_vld, bus.sof, bus.eof, bus.stat_vld,
         bus.stat_err, bus.stat_len, bus.out_byte,
         bus.pre_err_cnt};
    tests++;
    if (o !== 43'd0) begin
      $display("FAIL reset_outs got %h want 0", o);
      fails++;
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    o = {bus.out_vld, bus.sof, bus.eof, bus.stat_vld,
         bus.stat_err, bus.stat_len, bus.out_byte,
         bus.pre_err_cnt};
    tests++;
    if (o !== 43'd0) begin
      $display("FAIL idle_outs got %h want 0", o);
      fails++;
    end
  endtask

  task automatic test_good();
    int bad;
    clr();
    build(48'h02_00_00_00_00_01, 60);
    send_frame(60, 1'b1);
    settle();
    bad = 0;
    for (int i = 0; i < 60; i++)
      if (got[i] !== frm[i]) bad++;
    tests++;
    if (n_out != 60) begin
      $display("FAIL good_count got %0d want 60", n_out);
      fails++;
    end
    tests++;
    if (bad != 0) begin
      $display("FAIL good_data got %0d bad want 0", bad);
      fails++;
    end
    tests++;
    if (sof_n != 1 || sof_idx != 0) begin
      $display("FAIL good_sof got n=%0d idx=%0d want 1/0",
               sof_n, sof_idx);
      fails++;
    end
    tests++;
    if (eof_n != 1 || eof_idx != 59) begin
      $display("FAIL good_eof got n=%0d idx=%0d want 1/59",
               eof_n, eof_idx);
      fails++;
    end
    tests++;
    if (stat_n != 1) begin
      $display("FAIL good_stat_n got %0d want 1", stat_n);
      fails++;
    end
    tests++;
    if (s_err !== 4'b0000) begin
      $display("FAIL good_err got %b want 0000", s_err);
      fails++;
    end
    tests++;
    if (s_len !== 11'd60) begin
      $display("FAIL good_len got %0d want 60", s_len);
      fails++;
    end
  endtask

  task automatic test_crc();
    int bad;
    clr();
    build(48'h02_00_00_00_00_01, 60);
    flip_idx = 20;
    send_frame(60, 1'b1);
    flip_idx = -1;
    settle();
    bad = 0;
    for (int i = 0; i < 60; i++)
      if (got[i] !== (frm[i] ^ ((i == 20) ? 8'h10 : 8'h00)))
        bad++;
    tests++;
    if (n_out != 60 || bad != 0) begin
      $display("FAIL crc_data got n=%0d bad=%0d want 60/0",
               n_out, bad);
      fails++;
    end
    tests++;
    if (stat_n != 1 || s_err !== 4'b0001) begin
      $display("FAIL crc_err got n=%0d err=%b want 1/0001",
               stat_n, s_err);
      fails++;
    end
  endtask

  task automatic test_len();
    clr();
    build(48'hFF_FF_FF_FF_FF_FF, 1514);
    send_frame(1514, 1'b1);
    settle();
    tests++;
    if (n_out != 1514 || eof_idx != 1513) begin
      $display("FAIL max_count got %0d/%0d want 1514/1513",
               n_out, eof_idx);
      fails++;
    end
    tests++;
    if (stat_n != 1 || s_err !== 4'b0000 || s_len !== 11'd1514)
    begin
      $display("FAIL max_stat got n=%0d err=%b len=%0d want 1/0000/1514",
               stat_n, s_err, s_len);
      fails++;
    end
    clr();
    build(48'hFF_FF_FF_FF_FF_FF, 1515);
    send_frame(1515, 1'b1);
    settle();
    tests++;
    if (n_out != 1515) begin
      $display("FAIL over_count got %0d want 1515", n_out);
      fails++;
    end
    tests++;
    if (stat_n != 1 || s_err !== 4'b0010) begin
      $display("FAIL over_err got n=%0d err=%b want 1/0010",
               stat_n, s_err);
      fails++;
    end
    tests++;
    if (s_len !== 11'd1515) begin
      $display("FAIL over_len got %0d want 1515", s_len);
      fails++;
    end
  endtask

  task automatic test_preamble();
    clr();
    build(48'h02_00_00_00_00_01, 60);
    bad_pre = 3;
    send_frame(60, 1'b1);
    bad_pre = -1;
    settle();
    tests++;
    if (n_out != 0 || stat_n != 0) begin
      $display("FAIL pre_quiet got bytes=%0d stat=%0d want 0/0",
               n_out, stat_n);
      fails++;
    end
    tests++;
    if (bus.pre_err_cnt !== 16'd1) begin
      $display("FAIL pre_cnt got %0d want 1", bus.pre_err_cnt);
      fails++;
    end
    clr();
    send_frame(60, 1'b1);
    settle();
    tests++;
    if (n_out != 60 || stat_n != 1 || s_err !== 4'b0000) begin
      $display("FAIL pre_next got n=%0d st=%0d err=%b want 60/1/0000",
               n_out, stat_n, s_err);
      fails++;
    end
  endtask

  task automatic test_addr();
    clr();
    build(48'h02_00_00_00_00_02, 60);
    bus.promisc = 1'b0;
    send_frame(60, 1'b1);
    settle();
    tests++;
    if (stat_n != 1 || s_err !== 4'b0100) begin
      $display("FAIL addr_miss got n=%0d err=%b want 1/0100",
               stat_n, s_err);
      fails++;
    end
    clr();
    bus.promisc = 1'b1;
    send_frame(60, 1'b1);
    settle();
    bus.promisc = 1'b0;
    tests++;
    if (stat_n != 1 || s_err !== 4'b0000 || n_out != 60) begin
      $display("FAIL addr_promisc got n=%0d err=%b b=%0d want 1/0000/60",
               stat_n, s_err, n_out);
      fails++;
    end
  endtask

  task automatic test_runt();
    clr();
    build(48'h02_00_00_00_00_01, 3);
    send_frame(3, 1'b0);
    settle();
    tests++;
    if (n_out != 0 || eof_n != 0) begin
      $display("FAIL runt_bytes got %0d eof=%0d want 0/0",
               n_out, eof_n);
      fails++;
    end
    tests++;
    if (stat_n != 1 || s_err !== 4'b0111) begin
      $display("FAIL runt_err got n=%0d err=%b want 1/0111",
               stat_n, s_err);
      fails++;
    end
    tests++;
    if (s_len !== 11'd0) begin
      $display("FAIL runt_len got %0d want 0", s_len);
      fails++;
    end
  endtask

  task automatic test_rx_er();
    clr();
    build(48'h02_00_00_00_00_01, 60);
    er_idx = 30;
    send_frame(60, 1'b1);
    er_idx = -1;
    settle();
    tests++;
    if (stat_n != 1 || s_err !== 4'b1000) begin
      $display("FAIL rx_er got n=%0d err=%b want 1/1000",
               stat_n, s_err);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    clr();
    build(48'h02_00_00_00_00_01, 60);
    send_frame(60, 1'b1);
    send_frame(60, 1'b1);
    settle();
    tests++;
    if (n_out != 120) begin
      $display("FAIL b2b_count got %0d want 120", n_out);
      fails++;
    end
    tests++;
    if (sof_n != 2 || eof_n != 2) begin
      $display("FAIL b2b_marks got sof=%0d eof=%0d want 2/2",
               sof_n, eof_n);
      fails++;
    end
    tests++;
    if (stat_n != 2 || err_or !== 4'b0000) begin
      $display("FAIL b2b_stat got n=%0d err=%b want 2/0000",
               stat_n, err_or);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    logic [42:0] o;
    build(48'h02_00_00_00_00_01, 60);
    @(negedge clk);
    bus.rx_dv = 1'b1;
    for (int i = 0; i < 7; i++) put(8'h55, 1'b0);
    put(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) put(frm[i], 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    o = {bus.out_vld, bus.sof, bus.eof, bus.stat_vld,
         bus.stat_err, bus.stat_len, bus.out_byte,
         bus.pre_err_cnt};
    tests++;
    if (o !== 43'd0) begin
      $display("FAIL mid_reset_outs got %h want 0", o);
      fails++;
    end
    clr();
    for (int i = 20; i < 24; i++) put(frm[i], 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 24; i < 60; i++) put(frm[i], 1'b0);
    @(negedge clk);
    bus.in_vld = 1'b0;
    bus.rx_dv  = 1'b0;
    settle();
    tests++;
    if (n_out != 0 || stat_n != 0) begin
      $display("FAIL mid_reset_quiet got b=%0d st=%0d want 0/0",
               n_out, stat_n);
      fails++;
    end
  endtask

  initial begin
    bus.rx_dv   = 1'b0;
    bus.rx_er   = 1'b0;
    bus.in_vld  = 1'b0;
    bus.in_byte = 8'h00;
    bus.promisc = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    test_reset();
    test_good();
    test_crc();
    test_len();
    test_preamble();
    test_addr();
    test_runt();
    test_rx_er();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
